// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor: frequency checker and downstream reset releaser for the
// board PLL, clocked by the 50 MHz reference. A divided PLL toggle is counted
// over a fixed gate window; enough consecutive in-range windows declare lock
// and release o_rst_out after a hold period.
// Build option: PLL_MON_STICKY_EN -- a bad window in LOCKED goes to a terminal
// FAIL state (lock low, reset high until i_rst) instead of re-acquiring.
`timescale 1ns/1ps
module pll_clk_monitor #(
  parameter int GATE_CYCLES = 1000,
  parameter int EXP_CNT     = 250,
  parameter int TOL         = 4,
  parameter int GOOD_WIN    = 4,
  parameter int RST_HOLD    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mon_tog,
  output logic        o_lock,
  output logic        o_rst_out,
  output logic [15:0] o_meas,
  output logic        o_meas_vld,
  output logic        o_err,
  output logic [7:0]  o_fail_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_HOLD, S_LOCKED, S_FAIL} state_t;

  localparam int          LO_I      = (EXP_CNT > TOL) ? (EXP_CNT - TOL) : 0;
  localparam logic [16:0] LO        = 17'(LO_I);
  localparam logic [16:0] HI        = 17'(EXP_CNT + TOL);
  localparam logic [15:0] WIN_LAST  = 16'(GATE_CYCLES - 1);
  localparam logic [3:0]  GW        = 4'(GOOD_WIN);
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);

  state_t      r_state, w_state_n;
  logic        r_sync1, r_sync2, r_dly;
  logic [15:0] r_win_cnt, r_edge_cnt, r_meas;
  logic        r_meas_vld, r_err;
  logic [7:0]  r_fail_cnt, r_hold_cnt, w_hold_n;
  logic [3:0]  r_good_cnt, w_good_n;
  logic        w_edge, w_close, w_good, w_err;
  logic [16:0] w_meas_sum;
  logic [15:0] w_meas_next;

  // Both edges of the synchronized toggle count.
  assign w_edge      = r_sync2 ^ r_dly;
  // The window only runs once IDLE has been left, so ACQ starts at win_cnt 0.
  assign w_close     = (r_state != S_IDLE) && (r_win_cnt == WIN_LAST);
  // An edge landing on the closing cycle still belongs to the closing window.
  assign w_meas_sum  = {1'b0, r_edge_cnt} + {16'd0, w_edge};
  assign w_meas_next = w_meas_sum[16] ? 16'hFFFF : w_meas_sum[15:0];
  assign w_good      = ({1'b0, w_meas_next} >= LO) && ({1'b0, w_meas_next} <= HI);

  // Synchronizer, gate window, edge counter and measurement register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_dly      <= 1'b0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_meas     <= '0;
      r_meas_vld <= 1'b0;
    end else begin
      r_sync1    <= i_mon_tog;
      r_sync2    <= r_sync1;
      r_dly      <= r_sync2;
      r_meas_vld <= w_close;
      if (r_state == S_IDLE) begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
      end else if (w_close) begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
        r_meas     <= w_meas_next;
      end else begin
        r_win_cnt <= r_win_cnt + 16'd1;
        if (w_edge && (r_edge_cnt != 16'hFFFF)) r_edge_cnt <= r_edge_cnt + 16'd1;
      end
    end
  end

  // State register plus error pulse and saturating fail counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_good_cnt <= '0;
      r_hold_cnt <= '0;
      r_err      <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      r_state    <= w_state_n;
      r_good_cnt <= w_good_n;
      r_hold_cnt <= w_hold_n;
      r_err      <= w_err;
      if (w_err && (r_fail_cnt != 8'hFF)) r_fail_cnt <= r_fail_cnt + 8'd1;
    end
  end

  // Next-state logic; decisions use the closing window's count so the new
  // state lands on the same cycle as o_meas_vld.
  always_comb begin
    w_state_n = r_state;
    w_good_n  = r_good_cnt;
    w_hold_n  = r_hold_cnt;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_n = S_ACQ;
        w_good_n  = '0;
        w_hold_n  = '0;
      end
      S_ACQ: begin
        if (w_close) begin
          if (w_good) begin
            w_good_n = r_good_cnt + 4'd1;
            if ((r_good_cnt + 4'd1) == GW) begin
              w_state_n = S_HOLD;
              w_hold_n  = '0;
            end
          end else begin
            w_good_n = '0;
          end
        end
      end
      S_HOLD: begin
        if (w_close && !w_good) begin
          w_state_n = S_ACQ;
          w_good_n  = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_n = S_LOCKED;
        end else begin
          w_hold_n = r_hold_cnt + 8'd1;
        end
      end
      S_LOCKED: begin
        if (w_close && !w_good) begin
          w_err    = 1'b1;
          w_good_n = '0;
`ifdef PLL_MON_STICKY_EN
          w_state_n = S_FAIL;
`else
          w_state_n = S_ACQ;
`endif
        end
      end
      S_FAIL:  w_state_n = S_FAIL;
      default: w_state_n = S_IDLE;
    endcase
  end

  assign o_lock     = (r_state == S_HOLD) || (r_state == S_LOCKED);
  assign o_rst_out  = (r_state != S_LOCKED);
  assign o_meas     = r_meas;
  assign o_meas_vld = r_meas_vld;
  assign o_err      = r_err;
  assign o_fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Directed bench for pll_clk_monitor: one full-size instance (1000-cycle
// window) and one small instance (20-cycle window, hold longer than a window)
// for the hold-abort and fail-counter saturation scenarios.
`timescale 1ns/1ps
module tb_pll_clk_monitor;
  localparam int G  = 1000;
  localparam int SG = 20;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1, tog = 1'b0;
  logic        lock, rst_out, meas_vld, err;
  logic [15:0] meas;
  logic [7:0]  fail_cnt;

  logic        s_rst = 1'b1, s_tog = 1'b0;
  logic        s_lock, s_rst_out, s_meas_vld, s_err;
  logic [15:0] s_meas;
  logic [7:0]  s_fail_cnt;

  int checks = 0;
  int errors = 0;

  pll_clk_monitor dut (
    .i_clk(clk), .i_rst(rst), .i_mon_tog(tog), .o_lock(lock), .o_rst_out(rst_out),
    .o_meas(meas), .o_meas_vld(meas_vld), .o_err(err), .o_fail_cnt(fail_cnt));

  pll_clk_monitor #(.GATE_CYCLES(SG), .EXP_CNT(5), .TOL(1), .GOOD_WIN(1), .RST_HOLD(25)) u_s (
    .i_clk(clk), .i_rst(s_rst), .i_mon_tog(s_tog), .o_lock(s_lock), .o_rst_out(s_rst_out),
    .o_meas(s_meas), .o_meas_vld(s_meas_vld), .o_err(s_err), .o_fail_cnt(s_fail_cnt));

  // Reset the big instance; returns in the first ACQ cycle (win_cnt 0).
  task automatic do_reset();
    rst = 1'b1; tog = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Run len cycles from window offset 0, toggling ntog times every 3 cycles
  // from offset 50. Returns in the cycle after the window close.
  task automatic run_win(input int ntog, input int len, output int vld_n,
                         output int err_n, output int rst_fall);
    int t;
    t = 0; vld_n = 0; err_n = 0; rst_fall = -1;
    for (int i = 0; i < len; i++) begin
      if (i >= 1) begin
        if (meas_vld) vld_n++;
        if (err) err_n++;
      end
      if (rst_fall < 0 && !rst_out) rst_fall = i;
      if (i >= 50 && t < ntog && ((i - 50) % 3) == 0) begin tog = ~tog; t++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic s_reset();
    s_rst = 1'b1; s_tog = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    s_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Small-instance window: up to 5 toggles at offsets 2,5,8,11,14.
  task automatic run_swin(input int ntog, output int err_n, output int rst_fall);
    int t;
    t = 0; err_n = 0; rst_fall = -1;
    for (int i = 0; i < SG; i++) begin
      if (i >= 1 && s_err) err_n++;
      if (rst_fall < 0 && !s_rst_out) rst_fall = i;
      if (i >= 2 && t < ntog && ((i - 2) % 3) == 0) begin s_tog = ~s_tog; t++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", lock); end
    checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out got %b want 1", rst_out); end
    checks++; if (meas !== 16'd0) begin errors++; $display("FAIL reset_meas got %0d want 0", meas); end
    checks++; if (meas_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", meas_vld); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (fail_cnt !== 8'd0) begin errors++; $display("FAIL reset_fail_cnt got %0d want 0", fail_cnt); end
  endtask

  task automatic test_nominal();
    int v, e, rf;
    do_reset();
    for (int w = 1; w <= 4; w++) begin
      run_win(250, G, v, e, rf);
      checks++; if (v !== 0) begin errors++; $display("FAIL nom_spurious_vld w%0d got %0d want 0", w, v); end
      checks++; if (meas_vld !== 1'b1 || meas !== 16'd250) begin
        errors++; $display("FAIL nom_meas w%0d got vld=%b meas=%0d want vld=1 meas=250", w, meas_vld, meas); end
      checks++; if (lock !== (w == 4)) begin errors++; $display("FAIL nom_lock w%0d got %b want %b", w, lock, (w == 4)); end
      checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL nom_rst_out w%0d got %b want 1", w, rst_out); end
    end
    run_win(250, G, v, e, rf);
    checks++; if (rf !== 16) begin errors++; $display("FAIL nom_rst_fall got offset %0d want 16", rf); end
    checks++; if (lock !== 1'b1 || rst_out !== 1'b0) begin
      errors++; $display("FAIL nom_locked got lock=%b rst_out=%b want 1/0", lock, rst_out); end
  endtask

  task automatic test_dropout();
    int v, e, rf;
    run_win(0, G, v, e, rf);
    checks++; if (meas !== 16'd0 || meas_vld !== 1'b1) begin
      errors++; $display("FAIL drop_meas got vld=%b meas=%0d want 1/0", meas_vld, meas); end
    checks++; if (err !== 1'b1 || fail_cnt !== 8'd1) begin
      errors++; $display("FAIL drop_err got err=%b fail_cnt=%0d want 1/1", err, fail_cnt); end
    checks++; if (lock !== 1'b0 || rst_out !== 1'b1) begin
      errors++; $display("FAIL drop_lock got lock=%b rst_out=%b want 0/1", lock, rst_out); end
    for (int w = 1; w <= 4; w++) begin
      run_win(250, G, v, e, rf);
      checks++; if (e !== 0 && w == 1) begin errors++; $display("FAIL drop_err_width got %0d extra want 0", e); end
`ifdef PLL_MON_STICKY_EN
      checks++; if (lock !== 1'b0 || rst_out !== 1'b1 || meas_vld !== 1'b1 || meas !== 16'd250) begin
        errors++; $display("FAIL sticky_fail w%0d got lock=%b rst_out=%b vld=%b meas=%0d want 0/1/1/250",
                           w, lock, rst_out, meas_vld, meas); end
`else
      checks++; if (lock !== (w == 4)) begin errors++; $display("FAIL relock w%0d got %b want %b", w, lock, (w == 4)); end
`endif
    end
    checks++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL drop_fail_hold got %0d want 1", fail_cnt); end
  endtask

  task automatic test_mid_reset();
    int v, e, rf, cnt;
    run_win(250, 500, v, e, rf);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (lock !== 1'b0 || rst_out !== 1'b1 || meas !== 16'd0 || meas_vld !== 1'b0 ||
                  err !== 1'b0 || fail_cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_outputs got lock=%b rst_out=%b meas=%0d vld=%b err=%b fail=%0d want 0/1/0/0/0/0",
                         lock, rst_out, meas, meas_vld, err, fail_cnt); end
    rst = 1'b0;
    cnt = 1;  // the IDLE cycle right after release is cycle 1
    while (!meas_vld && cnt < 3000) begin @(posedge clk); #1; cnt++; end
    checks++; if (cnt !== G + 2) begin errors++; $display("FAIL midrst_first_vld got cycle %0d want %0d", cnt, G + 2); end
  endtask

  task automatic test_tolerance();
    int v, e, rf;
    int pat [4];
    pat = '{246, 246, 254, 254};
    do_reset();
    for (int w = 0; w < 4; w++) begin
      run_win(pat[w], G, v, e, rf);
      checks++; if (meas !== 16'(pat[w]) || lock !== (w == 3)) begin
        errors++; $display("FAIL tol_in w%0d got meas=%0d lock=%b want %0d/%b", w, meas, lock, pat[w], (w == 3)); end
    end
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int w = 0; w < 5; w++) begin
        run_win(k ? 255 : 245, G, v, e, rf);
        checks++; if (meas !== 16'(k ? 255 : 245) || lock !== 1'b0 || dut.r_good_cnt !== 4'd0) begin
          errors++; $display("FAIL tol_out n%0d w%0d got meas=%0d lock=%b good=%0d want %0d/0/0",
                             k ? 255 : 245, w, meas, lock, dut.r_good_cnt, k ? 255 : 245); end
      end
    end
  endtask

  task automatic test_hold_bad();
    int e, rf;
    s_reset();
    run_swin(5, e, rf);
    checks++; if (s_lock !== 1'b1 || s_rst_out !== 1'b1 || s_meas !== 16'd5) begin
      errors++; $display("FAIL hold_enter got lock=%b rst_out=%b meas=%0d want 1/1/5", s_lock, s_rst_out, s_meas); end
    run_swin(0, e, rf);
    checks++; if (s_lock !== 1'b0 || s_rst_out !== 1'b1 || s_err !== 1'b0 || rf !== -1) begin
      errors++; $display("FAIL hold_abort got lock=%b rst_out=%b err=%b rst_fall=%0d want 0/1/0/-1",
                         s_lock, s_rst_out, s_err, rf); end
    checks++; if (s_fail_cnt !== 8'd0) begin errors++; $display("FAIL hold_no_fail got %0d want 0", s_fail_cnt); end
  endtask

  task automatic test_saturation();
    int e, rf, pulses, want;
    s_reset();
    pulses = 0;
    for (int k = 1; k <= 300; k++) begin
      run_swin(5, e, rf);
      run_swin(5, e, rf);
      run_swin(0, e, rf);
      if (s_err) pulses++;
      if (k == 10 || k == 255 || k == 300) begin
`ifdef PLL_MON_STICKY_EN
        want = 1;
`else
        want = (k > 255) ? 255 : k;
`endif
        checks++; if (s_fail_cnt !== 8'(want)) begin
          errors++; $display("FAIL sat_fail_cnt k%0d got %0d want %0d", k, s_fail_cnt, want); end
      end
    end
`ifdef PLL_MON_STICKY_EN
    want = 1;
`else
    want = 300;
`endif
    checks++; if (pulses !== want) begin errors++; $display("FAIL sat_err_pulses got %0d want %0d", pulses, want); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dropout();
    test_mid_reset();
    test_tolerance();
    test_hold_bad();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
